// File: rtl/pixel_stream_scheduler.sv
// Frame/row/pixel-pair scheduler: VSYNC, then per row HSYNC followed by a DATA burst.
// Build option FRAME_REPEAT_EN: a finished frame restarts at VSYNC instead of going to IDLE.
module pixel_stream_scheduler #(
   parameter int IMAGE_WIDTH  = 768,
   parameter int IMAGE_HEIGHT = 512,
   parameter int START_DELAY  = 100,
   parameter int HSYNC_DELAY  = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        out_ready,
   output logic        vertical_Pulse,
   output logic        horizontal_Pulse,
   output logic        data_valid,
   output logic [9:0]  row,
   output logic [10:0] column,
   output logic [18:0] pixel_addr,
   output logic        sig_done,
   output logic        busy
);
   // state | meaning
   // IDLE  | waiting for start, all outputs low
   // VSYNC | frame lead-in, START_DELAY cycles
   // HSYNC | row lead-in, HSYNC_DELAY cycles
   // DATA  | one pixel pair per cycle with out_ready high
   // DONE  | single-cycle frame-complete pulse
   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DONE} state_t;

   localparam int CNT_MAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(START_DELAY - 1);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_DELAY - 1);
   localparam logic [10:0]      COL_LAST = 11'(IMAGE_WIDTH - 2);
   localparam logic [9:0]       ROW_LAST = 10'(IMAGE_HEIGHT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [9:0]        row_nxt;
   logic [10:0]       col_nxt;
   logic [18:0]       addr_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         row        <= '0;
         column     <= '0;
         pixel_addr <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         row        <= row_nxt;
         column     <= col_nxt;
         pixel_addr <= addr_nxt;
      end
   end

   // pixel_addr is tracked incrementally; stepping by 2 across a row end lands on (row+1)*IMAGE_WIDTH
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      row_nxt   = row;
      col_nxt   = column;
      addr_nxt  = pixel_addr;
      if (abort && state != S_IDLE) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         row_nxt   = '0;
         col_nxt   = '0;
         addr_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state_nxt = S_VSYNC;
                  cnt_nxt   = '0;
                  row_nxt   = '0;
                  col_nxt   = '0;
                  addr_nxt  = '0;
               end
            end
            S_VSYNC: begin
               if (cnt == VS_LAST) begin
                  state_nxt = S_HSYNC;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            S_HSYNC: begin
               if (cnt == HS_LAST) begin
                  state_nxt = S_DATA;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (out_ready) begin
                  if (column == COL_LAST) begin
                     if (row < ROW_LAST) begin
                        state_nxt = S_HSYNC;
                        row_nxt   = row + 10'd1;
                        col_nxt   = '0;
                        addr_nxt  = pixel_addr + 19'd2;
                     end else begin
                        state_nxt = S_DONE;
                        row_nxt   = '0;
                        col_nxt   = '0;
                        addr_nxt  = '0;
                     end
                  end else begin
                     col_nxt  = column + 11'd2;
                     addr_nxt = pixel_addr + 19'd2;
                  end
               end
            end
            S_DONE: begin
`ifdef FRAME_REPEAT_EN
               state_nxt = S_VSYNC;
`else
               state_nxt = S_IDLE;
`endif
               cnt_nxt   = '0;
               row_nxt   = '0;
               col_nxt   = '0;
               addr_nxt  = '0;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign vertical_Pulse   = (state == S_VSYNC);
   assign horizontal_Pulse = (state == S_HSYNC);
   assign data_valid       = (state == S_DATA);
   assign sig_done         = (state == S_DONE);
   assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_pixel_stream_scheduler.sv
// Bench for pixel_stream_scheduler: timeline vector table, hand-written reset/abort
// sequences, then random traffic against a beat-counting frame model.
module tb_pixel_stream_scheduler;
   localparam int W   = 8;
   localparam int H   = 4;
   localparam int SD  = 3;
   localparam int HD  = 2;
   localparam int BPR = W / 2;
`ifdef FRAME_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b1;
   logic        vertical_Pulse, horizontal_Pulse, data_valid, sig_done, busy;
   logic [9:0]  row;
   logic [10:0] column;
   logic [18:0] pixel_addr;

   pixel_stream_scheduler #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD), .HSYNC_DELAY(HD)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .out_ready(out_ready),
      .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
      .data_valid(data_valid), .row(row), .column(column), .pixel_addr(pixel_addr),
      .sig_done(sig_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef logic [44:0] obs_t;
   typedef struct {
      int   sid;
      int   cyc;
      obs_t exp;
   } vec_t;

   vec_t tbl[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic obs_t mk(logic vp, logic hp, logic dv, logic dn, logic bz,
                               int r, int c, int a);
      return {vp, hp, dv, dn, bz, 10'(r), 11'(c), 19'(a)};
   endfunction

   function automatic obs_t dut_obs();
      return {vertical_Pulse, horizontal_Pulse, data_valid, sig_done, busy,
              row, column, pixel_addr};
   endfunction

   task automatic check(string name, int cyc, obs_t exp);
      obs_t act;
      act = dut_obs();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got v%b h%b d%b s%b b%b r%0d c%0d a%0d want v%b h%b d%b s%b b%b r%0d c%0d a%0d",
                  name, cyc, act[44], act[43], act[42], act[41], act[40],
                  act[39:30], act[29:19], act[18:0], exp[44], exp[43], exp[42],
                  exp[41], exp[40], exp[39:30], exp[29:19], exp[18:0]);
      end
   endtask

   task automatic add(int sid, int cyc, obs_t exp);
      vec_t v;
      v.sid = sid;
      v.cyc = cyc;
      v.exp = exp;
      tbl.push_back(v);
   endtask

   // scenario stimulus: inputs driven in cycle k are sampled at the edge that opens cycle k+1
   function automatic logic sc_start(int sid, int k);
      return (k == 0) || (sid == 2 && k == 20) || (sid == 3 && (k == 2 || k == 7 || k == 16));
   endfunction
   function automatic logic sc_abort(int sid, int k);
      return (sid == 2 && k == 15);
   endfunction
   function automatic logic sc_ready(int sid, int k);
      return !(sid == 1 && k >= 7 && k <= 9);
   endfunction

   task automatic run_sc(int sid, int last);
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         foreach (tbl[i])
            if (tbl[i].sid == sid && tbl[i].cyc == k)
               check($sformatf("sc%0d", sid), k, tbl[i].exp);
         start     = sc_start(sid, k);
         abort     = sc_abort(sid, k);
         out_ready = sc_ready(sid, k);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      out_ready = 1'b1;
   endtask

   // reference model: frame progress is tracked as a count of accepted beats
   int m_mode;   // 0 idle, 1 vertical sync, 2 horizontal sync, 3 data, 4 done
   int m_wait;
   int m_beats;

   function automatic obs_t model_obs();
      int r, c, a;
      r = 0; c = 0; a = 0;
      if (m_mode == 2 || m_mode == 3) begin
         r = m_beats / BPR;
         c = 2 * (m_beats % BPR);
         a = 2 * m_beats;
      end
      return mk(m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 4, m_mode != 0, r, c, a);
   endfunction

   task automatic model_step(logic s, logic a, logic rd);
      if (a && m_mode != 0) begin
         m_mode  = 0;
         m_beats = 0;
      end else begin
         case (m_mode)
            0: if (s && !a) begin m_mode = 1; m_wait = SD; m_beats = 0; end
            1: begin m_wait--; if (m_wait == 0) begin m_mode = 2; m_wait = HD; end end
            2: begin m_wait--; if (m_wait == 0) m_mode = 3; end
            3: if (rd) begin
                  m_beats++;
                  if (m_beats == BPR * H) m_mode = 4;
                  else if (m_beats % BPR == 0) begin m_mode = 2; m_wait = HD; end
               end
            default: begin
               m_beats = 0;
               if (REP) begin m_mode = 1; m_wait = SD; end
               else m_mode = 0;
            end
         endcase
      end
   endtask

   obs_t idle_o;

   initial begin
      idle_o = mk(0, 0, 0, 0, 0, 0, 0, 0);

      // free-running frame
      add(0, 0, idle_o);
      add(0, 1, mk(1, 0, 0, 0, 1, 0, 0, 0));
      add(0, 3, mk(1, 0, 0, 0, 1, 0, 0, 0));
      add(0, 4, mk(0, 1, 0, 0, 1, 0, 0, 0));
      add(0, 5, mk(0, 1, 0, 0, 1, 0, 0, 0));
      add(0, 6, mk(0, 0, 1, 0, 1, 0, 0, 0));
      add(0, 7, mk(0, 0, 1, 0, 1, 0, 2, 2));
      add(0, 9, mk(0, 0, 1, 0, 1, 0, 6, 6));
      add(0, 10, mk(0, 1, 0, 0, 1, 1, 0, 8));
      add(0, 12, mk(0, 0, 1, 0, 1, 1, 0, 8));
      add(0, 15, mk(0, 0, 1, 0, 1, 1, 6, 14));
      add(0, 24, mk(0, 0, 1, 0, 1, 3, 0, 24));
      add(0, 27, mk(0, 0, 1, 0, 1, 3, 6, 30));
      add(0, 28, mk(0, 0, 0, 1, 1, 0, 0, 0));
      if (REP) begin
         add(0, 29, mk(1, 0, 0, 0, 1, 0, 0, 0));
         add(0, 31, mk(1, 0, 0, 0, 1, 0, 0, 0));
         add(0, 32, mk(0, 1, 0, 0, 1, 0, 0, 0));
         add(0, 34, mk(0, 0, 1, 0, 1, 0, 0, 0));
         add(0, 55, mk(0, 0, 1, 0, 1, 3, 6, 30));
         add(0, 56, mk(0, 0, 0, 1, 1, 0, 0, 0));
         add(0, 57, mk(1, 0, 0, 0, 1, 0, 0, 0));
      end else begin
         add(0, 29, idle_o);
         add(0, 31, idle_o);
      end
      // out_ready low in cycles 7-9
      add(1, 6, mk(0, 0, 1, 0, 1, 0, 0, 0));
      add(1, 7, mk(0, 0, 1, 0, 1, 0, 2, 2));
      add(1, 9, mk(0, 0, 1, 0, 1, 0, 2, 2));
      add(1, 10, mk(0, 0, 1, 0, 1, 0, 2, 2));
      add(1, 11, mk(0, 0, 1, 0, 1, 0, 4, 4));
      add(1, 12, mk(0, 0, 1, 0, 1, 0, 6, 6));
      add(1, 13, mk(0, 1, 0, 0, 1, 1, 0, 8));
      add(1, 30, mk(0, 0, 1, 0, 1, 3, 6, 30));
      add(1, 31, mk(0, 0, 0, 1, 1, 0, 0, 0));
      add(1, 32, REP ? mk(1, 0, 0, 0, 1, 0, 0, 0) : idle_o);
      // abort in cycle 15, restart in cycle 20
      add(2, 14, mk(0, 0, 1, 0, 1, 1, 4, 12));
      add(2, 15, mk(0, 0, 1, 0, 1, 1, 6, 14));
      add(2, 16, idle_o);
      add(2, 20, idle_o);
      add(2, 21, mk(1, 0, 0, 0, 1, 0, 0, 0));
      add(2, 23, mk(1, 0, 0, 0, 1, 0, 0, 0));
      add(2, 24, mk(0, 1, 0, 0, 1, 0, 0, 0));
      // stray start pulses mid-frame
      add(3, 3, mk(1, 0, 0, 0, 1, 0, 0, 0));
      add(3, 4, mk(0, 1, 0, 0, 1, 0, 0, 0));
      add(3, 8, mk(0, 0, 1, 0, 1, 0, 4, 4));
      add(3, 16, mk(0, 1, 0, 0, 1, 2, 0, 16));
      add(3, 17, mk(0, 1, 0, 0, 1, 2, 0, 16));
      add(3, 28, mk(0, 0, 0, 1, 1, 0, 0, 0));
      add(3, 29, REP ? mk(1, 0, 0, 0, 1, 0, 0, 0) : idle_o);

      // power-on reset
      #1 reset = 1'b0;
      #3 check("reset_state", 0, idle_o);
      @(negedge clk);
      reset = 1'b1;

      run_sc(0, REP ? 58 : 31);
      run_sc(1, 33);
      run_sc(2, 25);
      run_sc(3, 30);

      // start together with abort in IDLE is ignored
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 1, idle_o);

      // asynchronous reset in the middle of HSYNC
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 check("pre_reset_hsync", 4, mk(0, 1, 0, 0, 1, 0, 0, 0));
      reset = 1'b0;
      #1 check("async_reset", 4, idle_o);
      @(negedge clk);
      check("reset_held", 5, idle_o);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first_start_after_reset", 1, mk(1, 0, 0, 0, 1, 0, 0, 0));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // random traffic against the model
      m_mode  = 0;
      m_wait  = 0;
      m_beats = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         check("random", i, model_obs());
         start     = ($urandom_range(3) == 0);
         abort     = ($urandom_range(63) == 0);
         out_ready = ($urandom_range(3) != 0);
         model_step(start, abort, out_ready);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
